// File: rtl/piso_serializer_pkg.sv
// Shared constants, FSM state type and counter-width helper for the PISO serializer.
package piso_serializer_pkg;

    localparam int unsigned SER_N         = 8;
    localparam bit          SER_MSB_FIRST = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } piso_state_e;

    // Bit counter width for a word of n bits (n >= 2).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// N-bit shift register with parallel load; shifts toward the output end and fills with 0.
module piso_shift_reg
    import piso_serializer_pkg::*;
#(
    parameter int unsigned N         = SER_N,
    parameter bit          MSB_FIRST = SER_MSB_FIRST
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [N-1:0] din_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] sh_q;
    logic [N-1:0] sh_d;

    // Parallel load wins over shift.
    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = din_i;
        end else if (shift_i) begin
            sh_d = MSB_FIRST ? {sh_q[N-2:0], 1'b0} : {1'b0, sh_q[N-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q_o = sh_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with a one-word holding buffer and valid/ready backpressure.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned N         = SER_N,
    parameter bit          MSB_FIRST = SER_MSB_FIRST
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    input  logic [N-1:0] load_data,
    output logic         load_ready,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         ser_last,
    output logic         busy
);

    localparam int unsigned   CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    piso_state_e   state_q;
    piso_state_e   state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [N-1:0]  hold_q;
    logic [N-1:0]  hold_d;
    logic          hold_full_q;
    logic          hold_full_d;
    logic          drain;
    logic          shift_en;
    logic          active;
    logic          last;
    logic [N-1:0]  sh;

    assign active = (state_q == ST_SHIFT);
    assign last   = active && (cnt_q == CNT_LAST);

    // Next-state: accept into the buffer, drain into the shifter, step or finish the word.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        drain       = 1'b0;
        shift_en    = 1'b0;

        if (load_valid && !hold_full_q) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    drain = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (last) begin
                    if (hold_full_q) begin
                        drain = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Accept needs an empty buffer and drain a full one, so they never collide here.
        if (drain) begin
            state_d     = ST_SHIFT;
            cnt_d       = '0;
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    piso_shift_reg #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (drain),
        .shift_i (shift_en),
        .din_i   (hold_q),
        .q_o     (sh)
    );

    assign load_ready = ~hold_full_q;
    assign ser_out    = active & (MSB_FIRST ? sh[N-1] : sh[0]);
    assign ser_valid  = active;
    assign ser_last   = last;
    assign busy       = active | hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances against a word/bit-count model.
module tb_piso_serializer;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_valid;
    logic [N-1:0] load_data;

    logic lr_a, so_a, sv_a, sl_a, bz_a;
    logic lr_b, so_b, sv_b, sl_b, bz_b;

    int checks = 0;
    int errors = 0;

    // Model: word currently on the wire with bits remaining, plus one buffered word.
    logic [N-1:0] m_cur  = '0;
    logic [N-1:0] m_buf  = '0;
    int           m_rem  = 0;
    bit           m_bufv = 1'b0;

    logic [63:0] log_a, log_b, log_m;
    int          nlog, run, max_run, nlast;
    bit          mon_en = 1'b0;

    piso_serializer #(.N(N), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (lr_a),
        .ser_out    (so_a),
        .ser_valid  (sv_a),
        .ser_last   (sl_a),
        .busy       (bz_a)
    );

    piso_serializer #(.N(N), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (lr_b),
        .ser_out    (so_b),
        .ser_valid  (sv_b),
        .ser_last   (sl_b),
        .busy       (bz_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected serial bit: position k = N - m_rem within the current word.
    function automatic logic m_bit(input bit msb);
        if (m_rem == 0) return 1'b0;
        return msb ? m_cur[m_rem - 1] : m_cur[N - m_rem];
    endfunction

    always @(posedge clk) begin
        bit accept;
        bit drain;
        if (!rst_n) begin
            m_rem  = 0;
            m_bufv = 1'b0;
            m_cur  = '0;
            m_buf  = '0;
        end else begin
            accept = load_valid && !m_bufv;
            drain  = m_bufv && (m_rem <= 1);
            if (m_rem > 0) m_rem = m_rem - 1;
            if (drain) begin
                m_cur  = m_buf;
                m_rem  = N;
                m_bufv = 1'b0;
            end
            if (accept) begin
                m_buf  = load_data;
                m_bufv = 1'b1;
            end
        end
    end

    // Per-cycle compare of both instances against the model, plus bit logging.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ser_valid_msb",  64'(sv_a), 64'(m_rem > 0));
            chk("ser_valid_lsb",  64'(sv_b), 64'(m_rem > 0));
            chk("ser_out_msb",    64'(so_a), 64'(m_bit(1'b1)));
            chk("ser_out_lsb",    64'(so_b), 64'(m_bit(1'b0)));
            chk("ser_last_msb",   64'(sl_a), 64'(m_rem == 1));
            chk("ser_last_lsb",   64'(sl_b), 64'(m_rem == 1));
            chk("busy_msb",       64'(bz_a), 64'((m_rem > 0) || m_bufv));
            chk("busy_lsb",       64'(bz_b), 64'((m_rem > 0) || m_bufv));
            chk("load_ready_msb", 64'(lr_a), 64'(!m_bufv));
            chk("load_ready_lsb", 64'(lr_b), 64'(!m_bufv));
            if (sv_a) begin
                log_a = {log_a[62:0], so_a};
                log_b = {log_b[62:0], so_b};
                log_m = {log_m[62:0], m_bit(1'b1)};
                nlog++;
                run++;
                if (run > max_run) max_run = run;
                if (sl_a) nlast++;
            end else begin
                run = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        load_valid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic clr_log();
        log_a = '0; log_b = '0; log_m = '0;
        nlog = 0; run = 0; max_run = 0; nlast = 0;
    endtask

    // Present a word and hold it until accepted; load_valid stays high on return.
    task automatic send(input logic [N-1:0] w);
        bit acc;
        acc        = 1'b0;
        load_valid = 1'b1;
        load_data  = w;
        for (int i = 0; i < 40; i++) begin
            acc = lr_a;
            cyc();
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'(1));
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        clr_log();

        cyc();
        mon_en = 1'b1;
        cyc();
        chk("rst_ser_valid", 64'(sv_a), 64'(0));
        chk("rst_ser_out",   64'(so_a), 64'(0));
        chk("rst_busy",      64'(bz_a), 64'(0));
        rst_n = 1'b1;
        cyc();
        chk("rst_load_ready", 64'(lr_a), 64'(1));

        // Single word, first bit two edges after accept.
        clr_log();
        load_valid = 1'b1;
        load_data  = 8'b1010_1010;
        cyc();
        load_valid = 1'b0;
        chk("lat_t0_valid", 64'(sv_a), 64'(0));
        chk("lat_t0_busy",  64'(bz_a), 64'(1));
        cyc();
        chk("lat_t1_valid", 64'(sv_a), 64'(1));
        chk("lat_t1_out",   64'(so_a), 64'(1));
        idle(12);
        chk("single_msb_bits", 64'(log_a[7:0]), 64'(8'hAA));
        chk("single_lsb_bits", 64'(log_b[7:0]), 64'(8'h55));
        chk("single_model",    64'(log_m[7:0]), 64'(8'hAA));
        chk("single_count",    64'(nlog),  64'(8));
        chk("single_last",     64'(nlast), 64'(1));
        chk("single_busy_end", 64'(bz_a),  64'(0));

        // Back-to-back words stream with no gap.
        clr_log();
        send(8'b0101_0101);
        send(8'b1110_1010);
        idle(20);
        chk("b2b_bits",  64'(log_a[15:0]), 64'(16'b0101_0101_1110_1010));
        chk("b2b_model", 64'(log_m[15:0]), 64'(16'b0101_0101_1110_1010));
        chk("b2b_run",   64'(max_run), 64'(16));
        chk("b2b_last",  64'(nlast),   64'(2));

        // Backpressure: third word waits for the shifting word's last edge.
        clr_log();
        send(8'hCC);
        send(8'h33);
        load_data = 8'b0101_1111;
        chk("bp_ready_low", 64'(lr_a), 64'(0));
        chk("bp_busy",      64'(bz_a), 64'(1));
        send(8'b0101_1111);
        idle(30);
        chk("bp_bits",  64'(log_a[23:0]), 64'(24'hCC335F));
        chk("bp_count", 64'(nlog),    64'(24));
        chk("bp_run",   64'(max_run), 64'(24));

        // Reset during bit 4 with a word buffered.
        clr_log();
        send(8'b0111_1100);
        send(8'b1000_0000);
        load_valid = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("mid_rst_valid", 64'(sv_a), 64'(0));
        chk("mid_rst_out",   64'(so_a), 64'(0));
        chk("mid_rst_last",  64'(sl_a), 64'(0));
        chk("mid_rst_busy",  64'(bz_a), 64'(0));
        idle(15);
        chk("mid_rst_bits",  64'(log_a[3:0]), 64'(4'b0111));
        chk("mid_rst_count", 64'(nlog), 64'(4));
        clr_log();
        send(8'b0001_0001);
        idle(12);
        chk("post_rst_bits",  64'(log_a[7:0]), 64'(8'b0001_0001));
        chk("post_rst_count", 64'(nlog), 64'(8));

        // LSB-first instance emits bit 0 first.
        clr_log();
        send(8'b0000_0001);
        idle(12);
        chk("lsb_bits", 64'(log_b[7:0]), 64'(8'b1000_0000));
        chk("msb_bits", 64'(log_a[7:0]), 64'(8'b0000_0001));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
